// File: rtl/riscv_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_div_pkg
//  Description : Shared types and constants for the RV64M divide sequencer:
//                FSM state encoding and divctrl operation codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_div_pkg;

    // Sequencer states; IDLE is the only state in which a new op is taken.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } divseq_state_e;

    // divctrl encodings; bit2 marks a valid divide op, bit0 marks unsigned.
    localparam logic [2:0] DIVCTRL_DIV  = 3'b100;
    localparam logic [2:0] DIVCTRL_DIVU = 3'b101;
    localparam logic [2:0] DIVCTRL_REM  = 3'b110;
    localparam logic [2:0] DIVCTRL_REMU = 3'b111;

endpackage
`default_nettype wire

// File: rtl/riscv_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_div_step
//  Description : One radix-2 restoring divide step. Shifts {rem,quo} left by
//                one, trial-subtracts the divisor from the widened partial
//                remainder and sets the new quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_div_step
    import riscv_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    // Partial remainder after the shift is XLEN+1 bits so the MSB of rem is kept.
    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_trial;
    logic          w_fits;

    // Restoring step: keep the difference only when the divisor fits.
    always_comb begin
        w_shifted = {i_rem, i_quo[XLEN-1]};
        w_fits    = (w_shifted >= {1'b0, i_divisor});
        w_trial   = w_shifted - {1'b0, i_divisor};
        o_rem     = w_fits ? w_trial[XLEN-1:0] : w_shifted[XLEN-1:0];
        o_quo     = {i_quo[XLEN-2:0], w_fits};
    end

endmodule
`default_nettype wire

// File: rtl/riscv_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_div_sequencer
//  Description : Multi-cycle DIV/DIVU/REM/REMU sequencer for the EX stage.
//                One quotient bit per clock, RISC-V sign and special-case
//                handling (divide by zero, signed overflow), kill on flush.
//                Optional macro RISCV_DIV_EARLY_OUT_EN: divide-by-zero and
//                signed overflow skip the iteration phase (done at k+3).
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_div_sequencer
    import riscv_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_riscv_divseq_clk,
    input  logic            i_riscv_divseq_rst,
    input  logic            i_riscv_divseq_start,
    input  logic [2:0]      i_riscv_divseq_divctrl,
    input  logic [XLEN-1:0] i_riscv_divseq_rs1data,
    input  logic [XLEN-1:0] i_riscv_divseq_rs2data,
    input  logic            i_riscv_divseq_kill,
    output logic            o_riscv_divseq_ready,
    output logic            o_riscv_divseq_stall,
    output logic            o_riscv_divseq_done,
    output logic [XLEN-1:0] o_riscv_divseq_result
);

    localparam int              CNT_W     = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  C_MIN      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  C_ONES     = {XLEN{1'b1}};

    divseq_state_e    r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [XLEN-1:0]  r_rs1, r_rs2, r_rem, r_quo, r_divisor, r_result;
    logic             r_neg_q, r_neg_r, r_div0, r_ovf;

    logic             w_accept, w_signed, w_div0, w_ovf;
    logic [XLEN-1:0]  w_abs1, w_abs2, w_rem_nxt, w_quo_nxt, w_fix;

    assign w_accept = (r_state == IDLE) && i_riscv_divseq_start &&
                      i_riscv_divseq_divctrl[2] && !i_riscv_divseq_kill;
    assign w_signed = !r_op[0];
    assign w_div0   = (r_rs2 == '0);
    assign w_ovf    = w_signed && (r_rs1 == C_MIN) && (r_rs2 == C_ONES);
    assign w_abs1   = (w_signed && r_rs1[XLEN-1]) ? -r_rs1 : r_rs1;
    assign w_abs2   = (w_signed && r_rs2[XLEN-1]) ? -r_rs2 : r_rs2;

    riscv_div_step #(.XLEN(XLEN)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    // State register.
    always_ff @(posedge i_riscv_divseq_clk) begin
        if (i_riscv_divseq_rst) r_state <= IDLE;
        else                    r_state <= w_state_nxt;
    end

    // Next-state logic; kill returns to IDLE from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = PREP;
`ifdef RISCV_DIV_EARLY_OUT_EN
            PREP: w_state_nxt = (w_div0 || w_ovf) ? FIX : ITER;
`else
            PREP: w_state_nxt = ITER;
`endif
            ITER: if (r_cnt == C_CNT_LAST) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (i_riscv_divseq_kill) w_state_nxt = IDLE;
    end

    // Handshake outputs; stall covers the accept cycle through FIX.
    always_comb begin
        o_riscv_divseq_ready = (r_state == IDLE);
        o_riscv_divseq_done  = (r_state == DONE);
        o_riscv_divseq_stall = w_accept || (r_state == PREP) ||
                               (r_state == ITER) || (r_state == FIX);
    end

    // Final result select with div0/overflow overrides.
    always_comb begin
        w_fix = '0;
        case (r_op)
            DIVCTRL_DIV:  w_fix = r_div0 ? C_ONES : r_ovf ? r_rs1 : (r_neg_q ? -r_quo : r_quo);
            DIVCTRL_DIVU: w_fix = r_div0 ? C_ONES : r_quo;
            DIVCTRL_REM:  w_fix = r_div0 ? r_rs1  : r_ovf ? '0 : (r_neg_r ? -r_rem : r_rem);
            DIVCTRL_REMU: w_fix = r_div0 ? r_rs1  : r_rem;
            default:      w_fix = '0;
        endcase
    end

    // Datapath: operand capture, sign prep, iteration, result; frozen by kill.
    always_ff @(posedge i_riscv_divseq_clk) begin
        if (i_riscv_divseq_rst) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (!i_riscv_divseq_kill) begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op  <= i_riscv_divseq_divctrl;
                    r_rs1 <= i_riscv_divseq_rs1data;
                    r_rs2 <= i_riscv_divseq_rs2data;
                end
                PREP: begin
                    r_rem     <= '0;
                    r_quo     <= w_abs1;
                    r_divisor <= w_abs2;
                    r_cnt     <= '0;
                    r_neg_q   <= w_signed && (r_rs1[XLEN-1] ^ r_rs2[XLEN-1]);
                    r_neg_r   <= w_signed && r_rs1[XLEN-1];
                    r_div0    <= w_div0;
                    r_ovf     <= w_ovf;
                end
                ITER: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: r_result <= w_fix;
                default: ;
            endcase
        end
    end

    assign o_riscv_divseq_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_riscv_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_div_sequencer
//  Description : Self-checking bench for riscv_div_sequencer: directed corner
//                cases, kill/reset abort, held start, random ops vs. an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_div_sequencer;

    localparam int XLEN = 64;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef RISCV_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, kill = 1'b0;
    logic [2:0] divctrl = 3'b000;
    logic [63:0] rs1 = '0, rs2 = '0;
    logic ready, stall, done;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_result = '0;

    riscv_div_sequencer #(.XLEN(XLEN)) dut (
        .i_riscv_divseq_clk     (clk),
        .i_riscv_divseq_rst     (rst),
        .i_riscv_divseq_start   (start),
        .i_riscv_divseq_divctrl (divctrl),
        .i_riscv_divseq_rs1data (rs1),
        .i_riscv_divseq_rs2data (rs2),
        .i_riscv_divseq_kill    (kill),
        .o_riscv_divseq_ready   (ready),
        .o_riscv_divseq_stall   (stall),
        .o_riscv_divseq_done    (done),
        .o_riscv_divseq_result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RISC-V M-extension divide semantics in plain arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
        logic ovf;
        ovf = (a == MIN) && (b == ONES);
        case (c)
            3'b100:  ref_model = (b == 0) ? ONES : ovf ? a : 64'($signed(a) / $signed(b));
            3'b101:  ref_model = (b == 0) ? ONES : a / b;
            3'b110:  ref_model = (b == 0) ? a : ovf ? 64'd0 : 64'($signed(a) % $signed(b));
            default: ref_model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
        logic special;
        special = (b == 0) || (!c[0] && a == MIN && b == ONES);
        ref_latency = (EARLY && special) ? 3 : XLEN + 3;
    endfunction

    // Issue one op from IDLE and follow it to its done pulse.
    task automatic do_op(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
        int n, bad;
        start = 1'b1; divctrl = c; rs1 = a; rs2 = b;
        #1;
        check("accept_ready", 64'(ready), 64'd1);
        check("accept_stall", 64'(stall), 64'd1);
        tick();
        start = 1'b0; divctrl = 3'b000;
        n = 1; bad = 0;
        while (!done && n < 200) begin
            if (!stall || ready) bad++;
            tick();
            n++;
        end
        check("latency", 64'(n), 64'(ref_latency(c, a, b)));
        check("busy_flags", 64'(bad), 64'd0);
        check("done_stall", 64'(stall), 64'd0);
        check("result", result, ref_model(c, a, b));
        last_result = ref_model(c, a, b);
        tick();
        check("done_pulse", 64'(done), 64'd0);
        check("idle_ready", 64'(ready), 64'd1);
    endtask

    // Start an op, abort it n cycles after accept via kill or reset.
    task automatic abort_op(input int at, input bit use_rst);
        int dones;
        start = 1'b1; divctrl = 3'b100; rs1 = 64'd1000; rs2 = 64'd7;
        tick();
        start = 1'b0; divctrl = 3'b000;
        for (int i = 1; i < at; i++) tick();
        if (use_rst) rst = 1'b1; else kill = 1'b1;
        tick();
        rst = 1'b0; kill = 1'b0;
        check(use_rst ? "rst_ready" : "kill_ready", 64'(ready), 64'd1);
        check(use_rst ? "rst_stall" : "kill_stall", 64'(stall), 64'd0);
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) dones++;
            tick();
        end
        if (use_rst) last_result = '0;
        check(use_rst ? "rst_no_done" : "kill_no_done", 64'(dones), 64'd0);
        check(use_rst ? "rst_result" : "kill_result", result, last_result);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0: pick_operand = 64'd0;
            1: pick_operand = 64'd1;
            2: pick_operand = ONES;
            3: pick_operand = MIN;
            4: pick_operand = MAX;
            5: pick_operand = 64'($urandom_range(0, 100));
            default: pick_operand = {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int n;
        repeat (2) tick();
        rst = 1'b0;
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);

        do_op(3'b100, -64'sd20, 64'd3);
        do_op(3'b110, -64'sd20, 64'd3);
        do_op(3'b111, 64'd20, MIN);
        do_op(3'b101, 64'd100, 64'd7);
        do_op(3'b100, 64'd5, 64'd0);
        do_op(3'b110, 64'd5, 64'd0);
        do_op(3'b100, MIN, ONES);
        do_op(3'b110, MIN, ONES);
        do_op(3'b101, MIN, ONES);

        abort_op(30, 1'b0);
        abort_op(10, 1'b1);

        // start with kill in the same cycle is dropped
        start = 1'b1; kill = 1'b1; divctrl = 3'b101; rs1 = 64'd9; rs2 = 64'd2;
        #1;
        check("kill_start_stall", 64'(stall), 64'd0);
        tick();
        start = 1'b0; kill = 1'b0;
        check("kill_start_ready", 64'(ready), 64'd1);

        // start without a valid op code is ignored
        start = 1'b1; divctrl = 3'b001;
        #1;
        check("noop_stall", 64'(stall), 64'd0);
        tick();
        start = 1'b0; divctrl = 3'b000;
        check("noop_ready", 64'(ready), 64'd1);

        // start held high: one op per window, next accept right after DONE
        start = 1'b1; divctrl = 3'b101; rs1 = 64'd9; rs2 = 64'd2;
        for (int op = 0; op < 2; op++) begin
            tick();
            n = 1;
            while (!done && n < 200) begin tick(); n++; end
            check("held_latency", 64'(n), 64'(XLEN + 3));
            check("held_result", result, 64'd4);
            if (op == 1) start = 1'b0;
            tick();
            #1;
            check("held_ready", 64'(ready), 64'd1);
            check("held_stall", 64'(stall), (op == 0) ? 64'd1 : 64'd0);
        end
        last_result = 64'd4;

        for (int i = 0; i < 400; i++) begin
            logic [2:0] c;
            c = {1'b1, 2'($urandom_range(0, 3))};
            do_op(c, pick_operand(), pick_operand());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
